// File: rtl/rgmii_rx_frame_decoder.sv
// RGMII receive decoder: DDR samples -> DV/ER, byte assembly (GMII or MII nibbles), preamble/SFD strip, AXI-stream out.
// Latency: a non-last byte is emitted when the next byte is pushed; the last byte is emitted 1 cycle after the registered dv=0.
// Backpressure: none; the receive path cannot stall, and downstream must absorb one beat per cycle.
module rgmii_rx_frame_decoder #(
  parameter int MIN_FRAME_LEN_P = 64,
  parameter int MAX_FRAME_LEN_P = 1518,
  parameter int LEN_WIDTH_P     = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] rx_q1_i,
  input  logic [4:0] rx_q2_i,
  input  logic       mii_select_i,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  output logic       m_axis_tlast_o,
  output logic       m_axis_tuser_o,
  output logic       stat_good_o,
  output logic       stat_bad_o,
  output logic       stat_bad_sfd_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_DROP} state_t;

  localparam logic [LEN_WIDTH_P-1:0] MIN_LEN = LEN_WIDTH_P'(MIN_FRAME_LEN_P);
  localparam logic [LEN_WIDTH_P-1:0] MAX_LEN = LEN_WIDTH_P'(MAX_FRAME_LEN_P);

  state_t                 state, state_n;
  logic                   mii_mode;
  logic                   armed;
  // stage 0 registers
  logic                   dv_r, er_r, stb_r, odd_r, phase;
  logic [7:0]             byte_dat_r;
  logic [3:0]             nib_lo;
  // payload state
  logic                   hold_vld;
  logic [7:0]             hold_dat;
  logic [LEN_WIDTH_P-1:0] len;
  logic                   err;
  // FSM decisions
  logic                   push, emit, emit_last, emit_user, pay_entry;
  logic                   good, bad, bad_sfd, end_err;

  // Stage 0: decode RX_CTL into dv/er and assemble bytes in the current mode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dv_r       <= 1'b1;
      er_r       <= 1'b0;
      stb_r      <= 1'b0;
      odd_r      <= 1'b0;
      phase      <= 1'b0;
      byte_dat_r <= 8'h00;
      nib_lo     <= 4'h0;
    end else begin
      dv_r  <= rx_q1_i[4];
      er_r  <= rx_q1_i[4] ^ rx_q2_i[4];
      // phase before clearing tells us an odd nibble count when dv drops
      odd_r <= mii_mode & ~rx_q1_i[4] & phase;
      if (mii_mode) begin
        if (rx_q1_i[4]) begin
          phase <= ~phase;
          if (phase) begin
            byte_dat_r <= {rx_q1_i[3:0], nib_lo};
            stb_r      <= 1'b1;
          end else begin
            nib_lo <= rx_q1_i[3:0];
            stb_r  <= 1'b0;
          end
        end else begin
          phase <= 1'b0;
          stb_r <= 1'b0;
        end
      end else begin
        byte_dat_r <= {rx_q2_i[3:0], rx_q1_i[3:0]};
        stb_r      <= rx_q1_i[4];
        phase      <= 1'b0;
      end
    end
  end

  // Next-state and beat/stat decisions from the registered stage-0 outputs.
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_user = 1'b0;
    pay_entry = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    bad_sfd   = 1'b0;
    end_err   = err | (len < MIN_LEN) | (len > MAX_LEN) | odd_r;
    case (state)
      ST_IDLE: begin
        if (dv_r && stb_r && armed) begin
          if (byte_dat_r == 8'h55) begin
            state_n = ST_PRE;
          end else if (byte_dat_r == 8'hD5) begin
            state_n   = ST_PAY;
            pay_entry = 1'b1;
          end else begin
            state_n = ST_DROP;
            bad_sfd = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (!dv_r) begin
          state_n = ST_IDLE;
          bad_sfd = 1'b1;
        end else if (stb_r) begin
          if (byte_dat_r == 8'hD5) begin
            state_n   = ST_PAY;
            pay_entry = 1'b1;
          end else if (byte_dat_r != 8'h55) begin
            state_n = ST_DROP;
            bad_sfd = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (!dv_r) begin
          state_n = ST_IDLE;
          if (hold_vld) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_user = end_err;
            good      = ~end_err;
            bad       = end_err;
          end else begin
            bad = 1'b1;
          end
        end else if (stb_r) begin
          push = 1'b1;
          emit = hold_vld;
        end
      end
      ST_DROP: begin
        if (!dv_r) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, start arming, mode latch, hold register, length and error tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      mii_mode <= 1'b0;
      hold_vld <= 1'b0;
      hold_dat <= 8'h00;
      len      <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      // a frame may only start after dv has been seen low
      if (!dv_r) armed <= 1'b1;
      else if (state_n != ST_IDLE) armed <= 1'b0;
      if (state == ST_IDLE) mii_mode <= mii_select_i;
      if (push) begin
        hold_dat <= byte_dat_r;
        hold_vld <= 1'b1;
      end else if (state != ST_PAY || !dv_r) begin
        hold_vld <= 1'b0;
      end
      if (pay_entry) len <= '0;
      else if (push && len != '1) len <= len + LEN_WIDTH_P'(1);
      if (pay_entry) err <= 1'b0;
      else if (state == ST_PAY && dv_r && er_r) err <= 1'b1;
    end
  end

  // Output registers: data/last/user change only on an emitted beat; valid and stats are pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_axis_tdata_o  <= 8'h00;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tuser_o  <= 1'b0;
      stat_good_o     <= 1'b0;
      stat_bad_o      <= 1'b0;
      stat_bad_sfd_o  <= 1'b0;
    end else begin
      m_axis_tvalid_o <= emit;
      if (emit) begin
        m_axis_tdata_o <= hold_dat;
        m_axis_tlast_o <= emit_last;
        m_axis_tuser_o <= emit_user;
      end
      stat_good_o    <= good;
      stat_bad_o     <= bad;
      stat_bad_sfd_o <= bad_sfd;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_frame_decoder.sv
// Randomized bench for the RGMII receive decoder against a frame-level reference model.
// Latency: beats are collected on the falling edge and compared per frame after an idle gap.
// Backpressure: none; every emitted beat is captured.
module tb_rgmii_rx_frame_decoder;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [4:0] rx_q1_i, rx_q2_i;
  logic       mii_select_i;
  logic [7:0] m_axis_tdata_o;
  logic       m_axis_tvalid_o, m_axis_tlast_o, m_axis_tuser_o;
  logic       stat_good_o, stat_bad_o, stat_bad_sfd_o;

  always #5 clk_i = ~clk_i;

  rgmii_rx_frame_decoder dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .rx_q1_i         (rx_q1_i),
    .rx_q2_i         (rx_q2_i),
    .mii_select_i    (mii_select_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tuser_o  (m_axis_tuser_o),
    .stat_good_o     (stat_good_o),
    .stat_bad_o      (stat_bad_o),
    .stat_bad_sfd_o  (stat_bad_sfd_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_dat[$];
  bit         got_last[$];
  bit         got_user[$];
  int         n_good, n_bad, n_sfd;
  logic [7:0] wire_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // capture beats and stat pulses away from the active edge
  always @(negedge clk_i) begin
    if (m_axis_tvalid_o) begin
      got_dat.push_back(m_axis_tdata_o);
      got_last.push_back(m_axis_tlast_o);
      got_user.push_back(m_axis_tuser_o);
    end
    n_good += int'(stat_good_o);
    n_bad  += int'(stat_bad_o);
    n_sfd  += int'(stat_bad_sfd_o);
  end

  task automatic clear_capture();
    got_dat.delete(); got_last.delete(); got_user.delete();
    n_good = 0; n_bad = 0; n_sfd = 0;
  endtask

  task automatic cyc(input logic [4:0] a, input logic [4:0] b);
    rx_q1_i = a;
    rx_q2_i = b;
    @(posedge clk_i);
    #1;
  endtask

  // idle with random data and random false-carrier indications
  task automatic idle(input int n);
    repeat (n) cyc({1'b0, 4'($urandom)}, {1'($urandom), 4'($urandom)});
  endtask

  task automatic drive_byte(input bit mii, input logic [7:0] b, input bit er);
    if (mii) begin
      cyc({1'b1, b[3:0]}, {~er, b[3:0]});
      cyc({1'b1, b[7:4]}, {~er, b[7:4]});
    end else begin
      cyc({1'b1, b[3:0]}, {~er, b[7:4]});
    end
  endtask

  task automatic build(input int pre_n, input logic [7:0] sfd, input int len, input bit rnd);
    wire_q.delete();
    repeat (pre_n) wire_q.push_back(8'h55);
    wire_q.push_back(sfd);
    for (int i = 0; i < len; i++) wire_q.push_back(rnd ? 8'($urandom) : 8'(i));
  endtask

  // Frame-level expectations: skip 0x55s, need 0xD5, everything after is payload.
  task automatic check_frame(input string tag, input bit mii, input int er_pos, input bit extra);
    int  k = 0;
    bit  ok;
    int  n;
    bit  exp_user;
    int  bad_bytes = 0;
    int  bad_flags = 0;
    while (k < wire_q.size() && wire_q[k] == 8'h55) k++;
    ok = (k < wire_q.size()) && (wire_q[k] == 8'hD5);
    n  = ok ? wire_q.size() - k - 1 : 0;
    exp_user = (er_pos > k) || (n < MIN_LEN) || (n > MAX_LEN) || (mii && extra);
    check({tag, "_beats"}, got_dat.size(), n);
    if (got_dat.size() == n && n > 0) begin
      for (int i = 0; i < n; i++) begin
        if (got_dat[i] !== wire_q[k + 1 + i]) bad_bytes++;
        if (got_last[i] !== (i == n - 1)) bad_flags++;
        if (i < n - 1 && got_user[i] !== 1'b0) bad_flags++;
      end
      check({tag, "_data"}, bad_bytes, 0);
      check({tag, "_flags"}, bad_flags, 0);
      check({tag, "_tuser"}, got_user[n-1], exp_user);
    end
    check({tag, "_good"}, n_good, (ok && n > 0 && !exp_user) ? 1 : 0);
    check({tag, "_bad"}, n_bad, (ok && (n == 0 || exp_user)) ? 1 : 0);
    check({tag, "_badsfd"}, n_sfd, ok ? 0 : 1);
  endtask

  task automatic run_frame(input string tag, input bit mii, input int er_pos, input bit extra, input bit flip);
    mii_select_i = mii;
    idle(8);
    clear_capture();
    for (int i = 0; i < wire_q.size(); i++) begin
      if (flip && i == wire_q.size() - 1 && i >= 2) mii_select_i = ~mii;
      drive_byte(mii, wire_q[i], i == er_pos);
    end
    if (mii && extra) cyc({1'b1, 4'($urandom)}, {1'b1, 4'($urandom)});
    idle(10);
    check_frame(tag, mii, er_pos, extra);
  endtask

  initial begin
    int lens[9] = '{0, 1, 40, 63, 64, 65, 100, 150, 200};
    reset_i      = 1'b1;
    rx_q1_i      = 5'h00;
    rx_q2_i      = 5'h00;
    mii_select_i = 1'b0;
    clear_capture();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_state", {m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tuser_o,
                        stat_good_o, stat_bad_o, stat_bad_sfd_o}, 0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // directed: good GMII, error on byte 10, bad SFD then good frame
    build(7, 8'hD5, 64, 0);  run_frame("t1_gmii", 0, -1, 0, 0);
    build(7, 8'hD5, 64, 0);  run_frame("t2_er", 0, 18, 0, 0);
    wire_q = '{8'h55, 8'h55, 8'hAA, 8'h12, 8'h34, 8'h56};
    run_frame("t3_badsfd", 0, -1, 0, 0);
    build(7, 8'hD5, 64, 0);  run_frame("t3_next", 0, -1, 0, 0);
    // MII: clean frame, then one trailing nibble
    build(7, 8'hD5, 64, 0);  run_frame("t4_mii", 1, -1, 0, 0);
    build(7, 8'hD5, 64, 0);  run_frame("t4_odd", 1, -1, 1, 0);
    // runt and empty payload
    build(7, 8'hD5, 40, 1);  run_frame("t5_runt", 0, -1, 0, 0);
    build(7, 8'hD5, 0, 0);   run_frame("t5_empty", 0, -1, 0, 0);
    // length boundaries, and SFD without preamble
    build(0, 8'hD5, 63, 1);   run_frame("len63", 0, -1, 0, 0);
    build(1, 8'hD5, 64, 1);   run_frame("len64", 0, -1, 0, 1);
    build(7, 8'hD5, 1518, 1); run_frame("len1518", 0, -1, 0, 0);
    build(7, 8'hD5, 1519, 1); run_frame("len1519", 0, -1, 0, 0);

    // reset mid-payload with dv held
    build(7, 8'hD5, 100, 1);
    mii_select_i = 1'b0;
    idle(8);
    for (int i = 0; i < 28; i++) drive_byte(0, wire_q[i], 0);
    reset_i = 1'b1;
    drive_byte(0, wire_q[28], 0);
    @(negedge clk_i);
    check("t6_rst_out", {m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tuser_o,
                         stat_good_o, stat_bad_o, stat_bad_sfd_o}, 0);
    clear_capture();
    drive_byte(0, wire_q[29], 0);
    reset_i = 1'b0;
    for (int i = 30; i < wire_q.size(); i++) drive_byte(0, wire_q[i], 0);
    idle(10);
    check("t6_dropped_beats", got_dat.size(), 0);
    check("t6_dropped_stats", n_good + n_bad + n_sfd, 0);
    build(7, 8'hD5, 64, 0);  run_frame("t6_next", 0, -1, 0, 0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      bit         mii   = 1'($urandom);
      int         pre_n = $urandom_range(0, 7);
      int         len   = lens[$urandom_range(0, 8)];
      logic [7:0] sfd   = 8'hD5;
      int         er_pos = -1;
      bit         extra;
      if ($urandom_range(0, 7) == 0) begin
        sfd = 8'($urandom);
        if (sfd == 8'h55 || sfd == 8'hD5) sfd = 8'h00;
      end
      if (len > 0 && $urandom_range(0, 3) == 0) er_pos = pre_n + 1 + $urandom_range(0, len - 1);
      extra = mii && ($urandom_range(0, 3) == 0);
      build(pre_n, sfd, len, 1);
      run_frame($sformatf("rnd%0d", f), mii, er_pos, extra, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
